// File: rtl/axis_if_pkg.sv
// Shared AXI-Stream width defaults and FIFO helper types.
package axis_if_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;
    localparam int unsigned AXIS_ID_WIDTH   = 8;
    localparam int unsigned AXIS_DEST_WIDTH = 4;
    localparam int unsigned AXIS_USER_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        DROP = 1'b1
    } fifo_state_t;

    // Index width of a FIFO with the given number of entries.
    function automatic int unsigned fifo_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module axis_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

    // Entry write on an accepted upstream beat.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward and oversize-frame drop.
module axis_pkt_fifo
    import axis_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = AXIS_DATA_WIDTH,
    parameter int unsigned ID_WIDTH      = AXIS_ID_WIDTH,
    parameter int unsigned DEST_WIDTH    = AXIS_DEST_WIDTH,
    parameter int unsigned USER_WIDTH    = AXIS_USER_WIDTH,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned PACKET_MODE   = 0,
    parameter int unsigned DROP_OVERSIZE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic [DATA_WIDTH/8-1:0]     s_keep,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_last,
    input  logic [ID_WIDTH-1:0]         s_id,
    input  logic [DEST_WIDTH-1:0]       s_dest,
    input  logic [USER_WIDTH-1:0]       s_user,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic [DATA_WIDTH/8-1:0]     m_keep,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic [ID_WIDTH-1:0]         m_id,
    output logic [DEST_WIDTH-1:0]       m_dest,
    output logic [USER_WIDTH-1:0]       m_user,
    output logic [fifo_aw(DEPTH):0]     occupancy,
    output logic                        overflow,
    output logic                        good_frame
);

    localparam int unsigned AW = fifo_aw(DEPTH);
    localparam int unsigned KW = DATA_WIDTH / 8;
    localparam int unsigned EW = DATA_WIDTH + KW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  r_cmt_ptr;
    logic         r_active;
    fifo_state_t  r_state;
    fifo_state_t  w_state_nxt;

    logic         w_full;
    logic         w_empty;
    logic         w_wr;
    logic         w_rd;
    logic         w_drop_enter;
    logic         w_s_ready;
    logic         w_m_valid;
    logic         w_overflow;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;

    assign w_full  = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_m_valid = (PACKET_MODE != 0) ? (r_rd_ptr != r_cmt_ptr) : !w_empty;
    assign w_wr      = s_valid && w_s_ready && (r_state == IDLE);
    assign w_rd      = w_m_valid && m_ready;

    // Next state, upstream ready and drop pulse; only the packet-mode path can leave IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_drop_enter = 1'b0;
        w_overflow   = 1'b0;
        w_s_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                w_s_ready = r_active && !w_full;
                if ((PACKET_MODE != 0) && (DROP_OVERSIZE != 0) && w_full &&
                    (r_cmt_ptr == r_rd_ptr) && (r_wr_ptr != r_cmt_ptr)) begin
                    w_state_nxt  = DROP;
                    w_drop_enter = 1'b1;
                end
            end
            DROP: begin
                w_s_ready = r_active;
                if (s_valid && s_last) begin
                    w_overflow  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer update; entering DROP discards the partial frame by rewinding to the commit point.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cmt_ptr <= '0;
            r_active  <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_drop_enter) begin
                r_wr_ptr <= r_cmt_ptr;
            end else if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_INC;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_INC;
            end
            if (w_wr && s_last) begin
                r_cmt_ptr <= r_wr_ptr + PTR_INC;
            end
        end
    end

    assign w_wdata = {s_data, s_keep, s_last, s_id, s_dest, s_user};

    axis_fifo_ram #(
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign {m_data, m_keep, m_last, m_id, m_dest, m_user} = w_rdata;

    assign s_ready    = w_s_ready;
    assign m_valid    = w_m_valid;
    assign occupancy  = r_wr_ptr - r_rd_ptr;
    assign overflow   = w_overflow;
    assign good_frame = (PACKET_MODE != 0) && w_wr && s_last;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench: one stream-mode and one packet-mode FIFO against a frame-level model.
module tb_axis_pkt_fifo;

    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stream-mode DUT signals
    logic [31:0] sx_data = '0;
    logic [3:0]  sx_keep = '0;
    logic        sx_valid = 1'b0, sx_ready, sx_last = 1'b0;
    logic [7:0]  sx_id = '0;
    logic [3:0]  sx_dest = '0, sx_user = '0;
    logic [31:0] sx_m_data;
    logic [3:0]  sx_m_keep;
    logic        sx_m_valid, sx_m_ready = 1'b0, sx_m_last;
    logic [7:0]  sx_m_id;
    logic [3:0]  sx_m_dest, sx_m_user;
    logic [4:0]  sx_occ;
    logic        sx_ovf, sx_good;

    // Packet-mode DUT signals
    logic [31:0] px_data = '0;
    logic [3:0]  px_keep = '0;
    logic        px_valid = 1'b0, px_ready, px_last = 1'b0;
    logic [7:0]  px_id = '0;
    logic [3:0]  px_dest = '0, px_user = '0;
    logic [31:0] px_m_data;
    logic [3:0]  px_m_keep;
    logic        px_m_valid, px_m_ready = 1'b0, px_m_last;
    logic [7:0]  px_m_id;
    logic [3:0]  px_m_dest, px_m_user;
    logic [4:0]  px_occ;
    logic        px_ovf, px_good;

    axis_pkt_fifo #(
        .DATA_WIDTH(32), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(4),
        .DEPTH(DEPTH), .PACKET_MODE(0), .DROP_OVERSIZE(1)
    ) u_str (
        .clk(clk), .rst(rst),
        .s_data(sx_data), .s_keep(sx_keep), .s_valid(sx_valid), .s_ready(sx_ready),
        .s_last(sx_last), .s_id(sx_id), .s_dest(sx_dest), .s_user(sx_user),
        .m_data(sx_m_data), .m_keep(sx_m_keep), .m_valid(sx_m_valid), .m_ready(sx_m_ready),
        .m_last(sx_m_last), .m_id(sx_m_id), .m_dest(sx_m_dest), .m_user(sx_m_user),
        .occupancy(sx_occ), .overflow(sx_ovf), .good_frame(sx_good)
    );

    axis_pkt_fifo #(
        .DATA_WIDTH(32), .ID_WIDTH(8), .DEST_WIDTH(4), .USER_WIDTH(4),
        .DEPTH(DEPTH), .PACKET_MODE(1), .DROP_OVERSIZE(1)
    ) u_pkt (
        .clk(clk), .rst(rst),
        .s_data(px_data), .s_keep(px_keep), .s_valid(px_valid), .s_ready(px_ready),
        .s_last(px_last), .s_id(px_id), .s_dest(px_dest), .s_user(px_user),
        .m_data(px_m_data), .m_keep(px_m_keep), .m_valid(px_m_valid), .m_ready(px_m_ready),
        .m_last(px_m_last), .m_id(px_m_id), .m_dest(px_m_dest), .m_user(px_m_user),
        .occupancy(px_occ), .overflow(px_ovf), .good_frame(px_good)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t rnd_beat(input bit last);
        beat_t b;
        b.data = $urandom;
        b.keep = 4'($urandom);
        b.last = last;
        b.id   = 8'($urandom);
        b.dest = 4'($urandom);
        b.user = 4'($urandom);
        return b;
    endfunction

    // ---------------- reference model state ----------------
    beat_t s_exp[$];
    beat_t p_exp[$];
    beat_t p_pend[$];
    int    s_count = 0;
    bit    s_live  = 1'b0;
    int    p_good_exp = 0, p_good_seen = 0;
    int    p_ovf_exp  = 0, p_ovf_seen  = 0;

    // m_ready drive modes: 0 hold low, 1 hold high, 2 random
    int s_rmode = 0;
    int p_rmode = 0;

    initial forever begin
        @(posedge clk);
        #2;
        sx_m_ready = (s_rmode == 2) ? 1'($urandom_range(0, 1)) : (s_rmode == 1);
        px_m_ready = (p_rmode == 2) ? 1'($urandom_range(0, 1)) : (p_rmode == 1);
    end

    // Stream monitor: plain elastic FIFO, every accepted beat comes out in order.
    always @(negedge clk) begin
        beat_t mo, mi;
        if (rst) begin
            s_exp.delete();
            s_count = 0;
            s_live  = 1'b0;
        end else begin
            mo = {sx_m_data, sx_m_keep, sx_m_last, sx_m_id, sx_m_dest, sx_m_user};
            mi = {sx_data, sx_keep, sx_last, sx_id, sx_dest, sx_user};
            chk("s_occupancy", 64'(sx_occ), 64'(s_count));
            chk("s_ready", 64'(sx_ready), 64'(s_live && (s_count < DEPTH)));
            chk("s_m_valid", 64'(sx_m_valid), 64'(s_exp.size() != 0));
            chk("s_pulses", 64'({sx_ovf, sx_good}), 64'(0));
            if (sx_m_valid && s_exp.size() != 0) begin
                chk("s_beat", 64'(mo), 64'(s_exp[0]));
                if (sx_m_ready) void'(s_exp.pop_front());
            end
            if (sx_m_valid && sx_m_ready) s_count--;
            if (sx_valid && sx_ready) begin
                s_exp.push_back(mi);
                s_count++;
            end
            s_live = 1'b1;
        end
    end

    // Packet monitor: frames of <= DEPTH beats delivered whole after their last beat, longer ones dropped.
    always @(negedge clk) begin
        beat_t mo, mi;
        if (rst) begin
            p_exp.delete();
            p_pend.delete();
        end else begin
            mo = {px_m_data, px_m_keep, px_m_last, px_m_id, px_m_dest, px_m_user};
            mi = {px_data, px_keep, px_last, px_id, px_dest, px_user};
            if (px_ovf)  p_ovf_seen++;
            if (px_good) p_good_seen++;
            if (px_m_valid) begin
                if (p_exp.size() == 0) begin
                    chk("p_unexpected_beat", 64'(mo), 64'(0) ^ 64'(mo) ^ 64'hDEAD);
                end else begin
                    chk("p_beat", 64'(mo), 64'(p_exp[0]));
                    if (px_m_ready) void'(p_exp.pop_front());
                end
            end
            if (px_valid && px_ready) begin
                p_pend.push_back(mi);
                if (px_last) begin
                    if (p_pend.size() > DEPTH) begin
                        chk("p_drop_pulses", 64'({px_ovf, px_good}), 64'(2'b10));
                        p_ovf_exp++;
                    end else begin
                        chk("p_commit_pulses", 64'({px_ovf, px_good}), 64'(2'b01));
                        foreach (p_pend[i]) p_exp.push_back(p_pend[i]);
                        p_good_exp++;
                    end
                    p_pend.delete();
                end else begin
                    chk("p_mid_pulses", 64'({px_ovf, px_good}), 64'(0));
                end
            end else begin
                chk("p_idle_pulses", 64'({px_ovf, px_good}), 64'(0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic s_send(input beat_t b);
        bit ok = 1'b0;
        {sx_data, sx_keep, sx_last, sx_id, sx_dest, sx_user} = b;
        sx_valid = 1'b1;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            ok = sx_ready;
        end
        if (!ok) chk("s_send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        sx_valid = 1'b0;
    endtask

    task automatic p_send(input beat_t b);
        bit ok = 1'b0;
        {px_data, px_keep, px_last, px_id, px_dest, px_user} = b;
        px_valid = 1'b1;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            ok = px_ready;
        end
        if (!ok) chk("p_send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        px_valid = 1'b0;
    endtask

    task automatic p_frame(input int len);
        for (int i = 0; i < len; i++) p_send(rnd_beat(i == len - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_s();
        int c = 0;
        s_rmode = 1;
        while ((s_exp.size() != 0 || sx_m_valid) && c < 3000) begin
            idle(1);
            c++;
        end
        chk("s_drain", 64'(s_exp.size()), 64'(0));
    endtask

    task automatic drain_p();
        int c = 0;
        p_rmode = 1;
        while ((p_exp.size() != 0 || px_m_valid) && c < 3000) begin
            idle(1);
            c++;
        end
        chk("p_drain", 64'(p_exp.size()), 64'(0));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        beat_t b;
        int ovf0;

        // Reset state
        idle(3);
        chk("rst_s_ready", 64'({sx_ready, px_ready}), 64'(0));
        chk("rst_m_valid", 64'({sx_m_valid, px_m_valid}), 64'(0));
        chk("rst_occ", 64'({sx_occ, px_occ}), 64'(0));
        chk("rst_pulses", 64'({sx_ovf, sx_good, px_ovf, px_good}), 64'(0));
        rst = 1'b0;
        idle(1);
        chk("rst_release_ready", 64'({sx_ready, px_ready}), 64'(2'b11));

        // Stream: fill to full with m_ready low, then drain one beat per cycle
        s_rmode = 0;
        for (int i = 0; i < 16; i++) begin
            b = rnd_beat(1'b0);
            b.data = 32'(i);
            s_send(b);
        end
        chk("s_full_ready", 64'(sx_ready), 64'(0));
        chk("s_full_occ", 64'(sx_occ), 64'(16));
        s_rmode = 1;
        idle(16);
        chk("s_drain16_occ", 64'(sx_occ), 64'(0));
        chk("s_drain16_valid", 64'(sx_m_valid), 64'(0));

        // Stream: single beat latency, no bypass
        b = '{data: 32'hA5A5A5A5, keep: 4'hF, last: 1'b1, id: 8'h3C, dest: 4'h9, user: 4'h6};
        {sx_data, sx_keep, sx_last, sx_id, sx_dest, sx_user} = b;
        sx_valid = 1'b1;
        @(negedge clk);
        chk("s_no_bypass", 64'(sx_m_valid), 64'(0));
        @(posedge clk);
        #1;
        sx_valid = 1'b0;
        chk("s_lat_valid", 64'(sx_m_valid), 64'(1));
        chk("s_lat_beat", 64'({sx_m_data, sx_m_keep, sx_m_last, sx_m_id, sx_m_dest, sx_m_user}), 64'(b));
        drain_s();

        // Stream: random traffic with random backpressure
        s_rmode = 2;
        for (int i = 0; i < 200; i++) begin
            s_send(rnd_beat(1'($urandom_range(0, 1))));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain_s();

        // Packet: 4-beat frame held until its last beat is written
        p_rmode = 1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            b = rnd_beat(i == 3);
            {px_data, px_keep, px_last, px_id, px_dest, px_user} = b;
            px_valid = 1'b1;
            @(negedge clk);
            chk("p4_ready", 64'(px_ready), 64'(1));
            chk("p4_hold_valid", 64'(px_m_valid), 64'(0));
            chk("p4_good", 64'(px_good), 64'(i == 3));
            @(posedge clk);
            #1;
        end
        px_valid = 1'b0;
        chk("p4_release_valid", 64'(px_m_valid), 64'(1));
        drain_p();

        // Packet: oversize frame dropped, following frame intact
        ovf0 = p_ovf_seen;
        p_frame(20);
        p_frame(3);
        drain_p();
        chk("p_ovf_once", 64'(p_ovf_seen - ovf0), 64'(1));
        chk("p_ovf_occ", 64'(px_occ), 64'(0));

        // Packet: full of committed frames backpressures instead of dropping
        p_rmode = 0;
        idle(1);
        p_frame(8);
        p_frame(8);
        chk("p_full_occ", 64'(px_occ), 64'(16));
        b = rnd_beat(1'b0);
        {px_data, px_keep, px_last, px_id, px_dest, px_user} = b;
        px_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p_full_ready", 64'(px_ready), 64'(0));
        end
        p_rmode = 1;
        p_send(b);
        p_frame(1);
        drain_p();
        chk("p_full_noovf", 64'(p_ovf_seen - ovf0), 64'(1));

        // Exactly DEPTH-beat frame commits
        p_frame(16);
        drain_p();

        // Reset mid-frame
        p_rmode = 0;
        idle(1);
        for (int i = 0; i < 5; i++) p_send(rnd_beat(1'b0));
        chk("p_mid_occ", 64'(px_occ), 64'(5));
        rst = 1'b1;
        idle(1);
        chk("p_rst_valid", 64'(px_m_valid), 64'(0));
        chk("p_rst_occ", 64'(px_occ), 64'(0));
        chk("p_rst_ready", 64'(px_ready), 64'(0));
        idle(1);
        rst = 1'b0;
        idle(1);
        p_rmode = 1;
        p_frame(3);
        drain_p();

        // Packet: random frame lengths, some oversize, random backpressure
        p_rmode = 2;
        for (int f = 0; f < 30; f++) begin
            p_frame($urandom_range(1, 20));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        drain_p();

        idle(2);
        chk("end_s_occ", 64'(sx_occ), 64'(0));
        chk("end_p_occ", 64'(px_occ), 64'(0));
        chk("end_good_count", 64'(p_good_seen), 64'(p_good_exp));
        chk("end_ovf_count", 64'(p_ovf_seen), 64'(p_ovf_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
